// File: rtl/rank_filter_pkg.sv
// Shared rank-filter constants: kernel mode encodings and pipeline depth.
package rank_filter_pkg;

  typedef logic [1:0] rank_mode_t;

  localparam rank_mode_t RANK_MEDIAN  = 2'd0;
  localparam rank_mode_t RANK_MIN     = 2'd1;
  localparam rank_mode_t RANK_MAX     = 2'd2;
  localparam int         RANK_LATENCY = 4;

endpackage

// File: rtl/rank_filter_3x3_if.sv
// Pixel stream interface: raster input with strobe, filtered output with strobe/frame pulse.
interface rank_filter_3x3_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              pi_flag;
  logic [1:0]        rank_sel;
  logic [DATA_W-1:0] tx_data;
  logic              po_flag;
  logic              frame_done;

  modport master (output rx_data, pi_flag, rank_sel, input tx_data, po_flag, frame_done);
  modport slave  (input rx_data, pi_flag, rank_sel, output tx_data, po_flag, frame_done);
endinterface

// File: rtl/sort3.sv
// Combinational max/mid/min of three unsigned values.
module sort3 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] mid_o,
  output logic [DATA_W-1:0] min_o
);
  logic [DATA_W-1:0] hi_ab, lo_ab, hi_c_min;

  assign hi_ab    = (a_i > b_i) ? a_i : b_i;
  assign lo_ab    = (a_i > b_i) ? b_i : a_i;
  assign max_o    = (hi_ab > c_i) ? hi_ab : c_i;
  assign min_o    = (lo_ab < c_i) ? lo_ab : c_i;
  // middle = max(lo_ab, min(hi_ab, c))
  assign hi_c_min = (hi_ab < c_i) ? hi_ab : c_i;
  assign mid_o    = (lo_ab > hi_c_min) ? lo_ab : hi_c_min;
endmodule

// File: rtl/rank_filter_3x3.sv
// 3x3 rank filter (median; min/max too when RANK_FILTER_MINMAX_EN is defined), 4-cycle latency.
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COL_NUM = 1024,
  parameter int ROW_NUM = 768
) (
  input logic              sclk,
  input logic              rst_n,
  rank_filter_3x3_if.slave pix
);
  localparam int CW = $clog2(COL_NUM);
  localparam int RW = $clog2(ROW_NUM);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept, win_ok, frame_end;

  assign accept    = pix.pi_flag;
  assign win_ok    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign frame_end = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: asynchronous read so taps line up with rx_data in the same cycle.
  logic [DATA_W-1:0] lb1_mem [COL_NUM];
  logic [DATA_W-1:0] lb2_mem [COL_NUM];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  assign lb1_rd = lb1_mem[col_q];
  assign lb2_rd = lb2_mem[col_q];

  always_ff @(posedge sclk) begin
    if (accept) begin
      lb1_mem[col_q] <= pix.rx_data;
      lb2_mem[col_q] <= lb1_rd;
    end
  end

  logic [DATA_W-1:0] win_q [3][3];
  logic [2:0]        vld_q, last_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= pix.rx_data;
      end
      vld_q  <= {vld_q[1:0], win_ok};
      last_q <= {last_q[1:0], frame_end};
    end
  end

  logic [DATA_W-1:0] row_max [3], row_mid [3], row_min [3];
  logic [DATA_W-1:0] rmax_q [3], rmid_q [3], rmin_q [3];

  for (genvar r = 0; r < 3; r++) begin : g_row
    sort3 #(.DATA_W(DATA_W)) u_row (
      .a_i(win_q[r][0]), .b_i(win_q[r][1]), .c_i(win_q[r][2]),
      .max_o(row_max[r]), .mid_o(row_mid[r]), .min_o(row_min[r])
    );
  end

  logic [DATA_W-1:0] mx_hi, mx_mid, mx_lo, md_hi, md_mid, md_lo, mn_hi, mn_mid, mn_lo;

  sort3 #(.DATA_W(DATA_W)) u_col_max (
    .a_i(rmax_q[0]), .b_i(rmax_q[1]), .c_i(rmax_q[2]),
    .max_o(mx_hi), .mid_o(mx_mid), .min_o(mx_lo)
  );
  sort3 #(.DATA_W(DATA_W)) u_col_mid (
    .a_i(rmid_q[0]), .b_i(rmid_q[1]), .c_i(rmid_q[2]),
    .max_o(md_hi), .mid_o(md_mid), .min_o(md_lo)
  );
  sort3 #(.DATA_W(DATA_W)) u_col_min (
    .a_i(rmin_q[0]), .b_i(rmin_q[1]), .c_i(rmin_q[2]),
    .max_o(mn_hi), .mid_o(mn_mid), .min_o(mn_lo)
  );

  logic [DATA_W-1:0] lo_of_max_q, med_of_mid_q, hi_of_min_q;
  logic [DATA_W-1:0] fin_hi, median, fin_lo, result;
  logic [DATA_W-1:0] tx_q;
  logic              po_q, fd_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= '0;
        rmid_q[r] <= '0;
        rmin_q[r] <= '0;
      end
      lo_of_max_q  <= '0;
      med_of_mid_q <= '0;
      hi_of_min_q  <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= row_max[r];
        rmid_q[r] <= row_mid[r];
        rmin_q[r] <= row_min[r];
      end
      lo_of_max_q  <= mx_lo;
      med_of_mid_q <= md_mid;
      hi_of_min_q  <= mn_hi;
    end
  end

  sort3 #(.DATA_W(DATA_W)) u_final (
    .a_i(lo_of_max_q), .b_i(med_of_mid_q), .c_i(hi_of_min_q),
    .max_o(fin_hi), .mid_o(median), .min_o(fin_lo)
  );

  logic unused_ok;

`ifdef RANK_FILTER_MINMAX_EN
  // Mode travels with each pixel so a frame change never re-labels the previous frame's tail.
  rank_mode_t        mode_q, m1_q, m2_q, m3_q;
  logic [DATA_W-1:0] max_all_q, min_all_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= RANK_MEDIAN;
      m1_q      <= RANK_MEDIAN;
      m2_q      <= RANK_MEDIAN;
      m3_q      <= RANK_MEDIAN;
      max_all_q <= '0;
      min_all_q <= '0;
    end else begin
      if (accept && (row_q == '0) && (col_q == '0)) mode_q <= pix.rank_sel;
      m1_q      <= mode_q;
      m2_q      <= m1_q;
      m3_q      <= m2_q;
      max_all_q <= mx_hi;
      min_all_q <= mn_lo;
    end
  end

  always_comb begin
    result = median;
    case (m3_q)
      RANK_MIN: result = min_all_q;
      RANK_MAX: result = max_all_q;
      default:  result = median;
    endcase
  end

  assign unused_ok = ^{mx_mid, md_hi, md_lo, mn_mid, fin_hi, fin_lo};
`else
  assign result    = median;
  assign unused_ok = ^{mx_mid, md_hi, md_lo, mn_mid, fin_hi, fin_lo, mx_hi, mn_lo, pix.rank_sel};
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      po_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      if (vld_q[2]) tx_q <= result;
      po_q <= vld_q[2];
      fd_q <= vld_q[2] & last_q[2];
    end
  end

  assign pix.tx_data    = tx_q;
  assign pix.po_flag    = po_q;
  assign pix.frame_done = fd_q;
endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3 on an 8x6 frame with 10-bit pixels.
module tb_rank_filter_3x3;
  import rank_filter_pkg::*;

  localparam int DW = 10, CN = 8, RN = 6, NPIX = CN * RN, LAT = 4;
`ifdef RANK_FILTER_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic sclk = 1'b0;
  logic rst_n;
  always #5 sclk = ~sclk;

  rank_filter_3x3_if #(.DATA_W(DW)) pix ();
  rank_filter_3x3 #(.DATA_W(DW), .COL_NUM(CN), .ROW_NUM(RN)) dut (
    .sclk(sclk), .rst_n(rst_n), .pix(pix)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [DW-1:0] frm [NPIX];
  logic          ring_po [8];
  logic          ring_fd [8];
  logic [DW-1:0] ring_tx [8];
  logic [DW-1:0] last_tx, first_tx;
  int            out_cnt, cnt200, first_cyc, pix22_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] golden(input int r, input int c, input logic [1:0] mode);
    logic [DW-1:0] v [9];
    logic [DW-1:0] t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v[i*3+j] = frm[(r-2+i)*CN + (c-2+j)];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    case (mode)
      RANK_MIN: return v[0];
      RANK_MAX: return v[8];
      default:  return v[4];
    endcase
  endfunction

  task automatic clear_ring();
    for (int i = 0; i < 8; i++) begin ring_po[i] = 1'b0; ring_fd[i] = 1'b0; ring_tx[i] = '0; end
  endtask

  // Called at posedge+1: check this cycle's outputs, then drive this cycle's inputs.
  task automatic step(input logic pi, input int r, input int c, input logic [1:0] mode);
    int s, d;
    s = cyc % 8;
    check("po_flag", 32'(pix.po_flag), 32'(ring_po[s]));
    check("frame_done", 32'(pix.frame_done), 32'(ring_fd[s]));
    if (ring_po[s]) begin
      check("tx_data", 32'(pix.tx_data), 32'(ring_tx[s]));
      last_tx = ring_tx[s];
    end else begin
      check("tx_hold", 32'(pix.tx_data), 32'(last_tx));
    end
    if (pix.po_flag === 1'b1) begin
      out_cnt++;
      if (pix.tx_data == DW'(200)) cnt200++;
      if (first_cyc < 0) begin first_cyc = cyc; first_tx = pix.tx_data; end
    end
    ring_po[s] = 1'b0;
    ring_fd[s] = 1'b0;
    pix.pi_flag = pi;
    pix.rx_data = pi ? frm[r*CN + c] : DW'($urandom);
    if (pi && r >= 2 && c >= 2) begin
      d = (cyc + LAT) % 8;
      ring_po[d] = 1'b1;
      ring_tx[d] = golden(r, c, mode);
      ring_fd[d] = (r == RN - 1) && (c == CN - 1);
    end
    if (pi && r == 2 && c == 2) pix22_cyc = cyc;
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic do_abort(input logic [1:0] mode);
    step(1'b0, 0, 0, mode);
    #2 rst_n = 1'b0;
    #1;
    check("abort_po", 32'(pix.po_flag), 32'd0);
    check("abort_fd", 32'(pix.frame_done), 32'd0);
    check("abort_tx", 32'(pix.tx_data), 32'd0);
    clear_ring();
    last_tx = '0;
    @(posedge sclk);
    #1;
    cyc++;
    step(1'b0, 0, 0, mode);
    step(1'b0, 0, 0, mode);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 0, 0, mode);
  endtask

  task automatic run_frame(input bit gaps, input logic [1:0] sel0, input int chg_idx,
                           input logic [1:0] sel1, input int abort_idx, input bit drain);
    logic [1:0] mode;
    mode = (MINMAX && (sel0 == RANK_MIN || sel0 == RANK_MAX)) ? sel0 : RANK_MEDIAN;
    out_cnt = 0;
    cnt200 = 0;
    first_cyc = -1;
    pix.rank_sel = sel0;
    for (int idx = 0; idx < NPIX; idx++) begin
      if (idx == abort_idx) begin
        do_abort(mode);
        return;
      end
      if (idx == chg_idx) pix.rank_sel = sel1;
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 0, 0, mode);
      step(1'b1, idx / CN, idx % CN, mode);
    end
    if (drain) repeat (6) step(1'b0, 0, 0, mode);
  endtask

  initial begin
    rst_n = 1'b0;
    pix.pi_flag = 1'b0;
    pix.rx_data = '0;
    pix.rank_sel = 2'd0;
    last_tx = '0;
    first_tx = '0;
    pix22_cyc = 0;
    clear_ring();
    #3;
    check("rst_tx", 32'(pix.tx_data), 32'd0);
    check("rst_po", 32'(pix.po_flag), 32'd0);
    check("rst_fd", 32'(pix.frame_done), 32'd0);
    @(posedge sclk); #1;
    @(posedge sclk); #1;
    rst_n = 1'b1;

    // ramp 0..47, median, gapless
    for (int i = 0; i < NPIX; i++) frm[i] = DW'(i);
    run_frame(1'b0, 2'd0, -1, 2'd0, -1, 1'b1);
    check("ramp_count", 32'(out_cnt), 32'd24);
    check("ramp_first", 32'(first_tx), 32'd9);
    check("ramp_latency", 32'(first_cyc - pix22_cyc), 32'd4);

    // flat 5 with a single 200 at (3,3)
    for (int i = 0; i < NPIX; i++) frm[i] = DW'(5);
    frm[3*CN + 3] = DW'(200);
    run_frame(1'b0, 2'd0, -1, 2'd0, -1, 1'b1);
    check("spike_med_200s", 32'(cnt200), 32'd0);
    check("spike_med_count", 32'(out_cnt), 32'd24);
    run_frame(1'b0, 2'd2, -1, 2'd2, -1, 1'b1);
    check("spike_max_200s", 32'(cnt200), MINMAX ? 32'd9 : 32'd0);
    run_frame(1'b1, 2'd2, -1, 2'd2, -1, 1'b1);
    check("spike_gap_200s", 32'(cnt200), MINMAX ? 32'd9 : 32'd0);
    check("spike_gap_count", 32'(out_cnt), 32'd24);

    // ramp again with random input gaps
    for (int i = 0; i < NPIX; i++) frm[i] = DW'(i);
    run_frame(1'b1, 2'd0, -1, 2'd0, -1, 1'b1);
    check("ramp_gap_count", 32'(out_cnt), 32'd24);
    check("ramp_gap_first", 32'(first_tx), 32'd9);

    // rank_sel changes at (3,4): median holds, min next frame (back-to-back frames)
    for (int i = 0; i < NPIX; i++) frm[i] = DW'($urandom_range(0, 1023));
    run_frame(1'b0, 2'd0, 3*CN + 4, 2'd1, -1, 1'b0);
    run_frame(1'b0, 2'd1, -1, 2'd1, -1, 1'b1);

    // reset at (4,5), then a clean frame from (0,0)
    for (int i = 0; i < NPIX; i++) frm[i] = DW'($urandom_range(0, 3));
    run_frame(1'b0, 2'd0, -1, 2'd0, 4*CN + 5, 1'b1);
    run_frame(1'b0, 2'd0, -1, 2'd0, -1, 1'b1);
    check("post_abort_count", 32'(out_cnt), 32'd24);

    // heavy ties, max and min with gaps, then full-range random median
    run_frame(1'b1, 2'd2, -1, 2'd2, -1, 1'b1);
    run_frame(1'b1, 2'd1, -1, 2'd1, -1, 1'b1);
    for (int i = 0; i < NPIX; i++) frm[i] = DW'($urandom_range(0, 1023));
    run_frame(1'b0, 2'd3, -1, 2'd3, -1, 1'b1);
    check("rand_count", 32'(out_cnt), 32'd24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
